// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the core's instruction/data ports, the arbiter and the shared memory bus.
// The master modport is the arbiter's view; slave is the view of the core plus bus side.
interface mem_bus_arbiter_if;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;

  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;

  logic        creq_valid;
  logic        creq_is_write;
  logic [2:0]  creq_size;
  logic [63:0] creq_addr;
  logic [7:0]  creq_strobe;
  logic [63:0] creq_data;
  logic        cresp_ready;
  logic        cresp_last;
  logic [63:0] cresp_data;

  modport master (
    input  ireq_valid, ireq_addr,
    output iresp_addr_ok, iresp_data_ok, iresp_data,
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data,
    output creq_valid, creq_is_write, creq_size, creq_addr, creq_strobe, creq_data,
    input  cresp_ready, cresp_last, cresp_data
  );

  modport slave (
    output ireq_valid, ireq_addr,
    input  iresp_addr_ok, iresp_data_ok, iresp_data,
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data,
    input  creq_valid, creq_is_write, creq_size, creq_addr, creq_strobe, creq_data,
    output cresp_ready, cresp_last, cresp_data
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Merges instruction and data requests onto one shared single-beat memory bus,
// one outstanding transfer at a time, with a registered one-cycle completion pulse.
module mem_bus_arbiter #(
  parameter bit DATA_PRIORITY = 1'b1
) (
  input logic              clk,
  input logic              reset,
  mem_bus_arbiter_if.master bus
);

  typedef enum logic [2:0] {StIdle, StBusyI, StBusyD, StRespI, StRespD} state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;  // 1 = data port was granted last
  logic [63:0] addr_q;
  logic [2:0]  size_q;
  logic [7:0]  strobe_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic        word_sel_q;

  logic grant_d;
  logic grant_i;
  logic beat_done;
  logic busy;

  assign grant_d   = bus.dreq_valid && (!bus.ireq_valid || DATA_PRIORITY || !last_grant_q);
  assign grant_i   = bus.ireq_valid && !grant_d;
  assign beat_done = bus.cresp_ready && bus.cresp_last;
  assign busy      = (state_q == StBusyI) || (state_q == StBusyD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          state_d      = StBusyD;
          last_grant_d = 1'b1;
        end else if (grant_i) begin
          state_d      = StBusyI;
          last_grant_d = 1'b0;
        end
      end
      StBusyI: if (beat_done) state_d = StRespI;
      StBusyD: if (beat_done) state_d = StRespD;
      // The client still shows the finished request here, so never grant in RESP.
      StRespI, StRespD: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request latch is normalised at grant time so the bus side reads it directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      size_q     <= '0;
      strobe_q   <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      word_sel_q <= 1'b0;
    end else begin
      if (state_q == StIdle && grant_d) begin
        addr_q   <= bus.dreq_addr;
        size_q   <= bus.dreq_size;
        strobe_q <= bus.dreq_strobe;
        wdata_q  <= bus.dreq_data;
      end else if (state_q == StIdle && grant_i) begin
        addr_q   <= bus.ireq_addr;
        size_q   <= 3'd2;
        strobe_q <= '0;
        wdata_q  <= '0;
      end
      if (busy && beat_done) begin
        rdata_q    <= bus.cresp_data;
        word_sel_q <= addr_q[2];
      end
    end
  end

  always_comb begin
    bus.creq_valid    = 1'b0;
    bus.creq_is_write = 1'b0;
    bus.creq_size     = '0;
    bus.creq_addr     = '0;
    bus.creq_strobe   = '0;
    bus.creq_data     = '0;
    bus.iresp_addr_ok = 1'b0;
    bus.iresp_data_ok = 1'b0;
    bus.dresp_addr_ok = 1'b0;
    bus.dresp_data_ok = 1'b0;
    bus.iresp_data    = word_sel_q ? rdata_q[63:32] : rdata_q[31:0];
    bus.dresp_data    = rdata_q;
    if (busy) begin
      bus.creq_valid    = 1'b1;
      bus.creq_is_write = (strobe_q != 8'h00);
      bus.creq_size     = size_q;
      bus.creq_addr     = addr_q;
      bus.creq_strobe   = strobe_q;
      bus.creq_data     = wdata_q;
    end
    if (state_q == StRespI) begin
      bus.iresp_addr_ok = 1'b1;
      bus.iresp_data_ok = 1'b1;
    end
    if (state_q == StRespD) begin
      bus.dresp_addr_ok = 1'b1;
      bus.dresp_data_ok = 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fixed-priority instance plus a round-robin instance.
module tb_mem_bus_arbiter;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  mem_bus_arbiter_if bi ();
  mem_bus_arbiter_if br ();

  mem_bus_arbiter #(.DATA_PRIORITY(1'b1)) u_dut_fix (.clk(clk), .reset(reset), .bus(bi));
  mem_bus_arbiter #(.DATA_PRIORITY(1'b0)) u_dut_rr  (.clk(clk), .reset(reset), .bus(br));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bi.ireq_valid = 0; bi.ireq_addr = '0;
    bi.dreq_valid = 0; bi.dreq_addr = '0; bi.dreq_size = '0;
    bi.dreq_strobe = '0; bi.dreq_data = '0;
    bi.cresp_ready = 0; bi.cresp_last = 0; bi.cresp_data = '0;
    br.ireq_valid = 0; br.ireq_addr = '0;
    br.dreq_valid = 0; br.dreq_addr = '0; br.dreq_size = '0;
    br.dreq_strobe = '0; br.dreq_data = '0;
    br.cresp_ready = 0; br.cresp_last = 0; br.cresp_data = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_creq_valid", 64'(bi.creq_valid), 64'd0);
    check("rst_iok", 64'(bi.iresp_data_ok), 64'd0);
    check("rst_dok", 64'(bi.dresp_data_ok), 64'd0);
    check("rst_dresp_data", bi.dresp_data, 64'd0);

    // Instruction fetch, immediate bus answer; client keeps valid through RESP_I.
    bi.ireq_valid = 1; bi.ireq_addr = 64'h8000_0004;
    tick();
    check("i_creq_valid", 64'(bi.creq_valid), 64'd1);
    check("i_creq_addr", bi.creq_addr, 64'h8000_0004);
    check("i_creq_size", 64'(bi.creq_size), 64'd2);
    check("i_creq_wr", 64'(bi.creq_is_write), 64'd0);
    check("i_ok_early", 64'(bi.iresp_data_ok), 64'd0);
    bi.cresp_ready = 1; bi.cresp_last = 1; bi.cresp_data = 64'hDEADBEEF_00000013;
    tick();
    bi.cresp_ready = 0; bi.cresp_last = 0;
    check("i_ok", 64'(bi.iresp_data_ok), 64'd1);
    check("i_addr_ok", 64'(bi.iresp_addr_ok), 64'd1);
    check("i_no_dok", 64'(bi.dresp_data_ok), 64'd0);
    check("i_data", 64'(bi.iresp_data), 64'hDEADBEEF);
    check("i_resp_no_req", 64'(bi.creq_valid), 64'd0);
    tick();
    check("i_idle_no_req", 64'(bi.creq_valid), 64'd0);
    check("i_ok_single", 64'(bi.iresp_data_ok), 64'd0);
    check("i_data_hold", 64'(bi.iresp_data), 64'hDEADBEEF);
    tick();
    check("i2_creq_valid", 64'(bi.creq_valid), 64'd1);
    bi.ireq_addr = 64'h9999_0000;
    #1;
    check("i2_addr_latched", bi.creq_addr, 64'h8000_0004);
    bi.cresp_ready = 1; bi.cresp_last = 1; bi.cresp_data = 64'hABCD0123_CAFEF00D;
    tick();
    bi.cresp_ready = 0; bi.cresp_last = 0;
    bi.ireq_valid = 0;
    check("i2_ok", 64'(bi.iresp_data_ok), 64'd1);
    check("i2_data", 64'(bi.iresp_data), 64'hABCD0123);
    tick();

    // Store with a slow slave; a ready-without-last beat must be ignored.
    bi.dreq_valid = 1; bi.dreq_addr = 64'h8000_1000; bi.dreq_size = 3;
    bi.dreq_strobe = 8'hFF; bi.dreq_data = 64'h1122334455667788;
    tick();
    bi.dreq_addr = 64'h0; bi.dreq_strobe = 8'h00; bi.dreq_data = 64'h0; bi.dreq_size = 0;
    for (int i = 0; i < 6; i++) begin
      check("d_busy_valid", 64'(bi.creq_valid), 64'd1);
      check("d_busy_addr", bi.creq_addr, 64'h8000_1000);
      check("d_busy_data", bi.creq_data, 64'h1122334455667788);
      check("d_busy_wr", 64'(bi.creq_is_write), 64'd1);
      check("d_busy_strb", 64'(bi.creq_strobe), 64'hFF);
      check("d_busy_size", 64'(bi.creq_size), 64'd3);
      check("d_busy_no_ok", 64'(bi.dresp_data_ok), 64'd0);
      bi.cresp_ready = (i == 2 || i == 5);
      bi.cresp_last  = (i == 5);
      bi.cresp_data  = 64'h5555AAAA0000FFFF;
      tick();
    end
    bi.cresp_ready = 0; bi.cresp_last = 0;
    bi.dreq_valid = 0;
    check("d_ok", 64'(bi.dresp_data_ok), 64'd1);
    check("d_addr_ok", 64'(bi.dresp_addr_ok), 64'd1);
    check("d_no_iok", 64'(bi.iresp_data_ok), 64'd0);
    check("d_data", bi.dresp_data, 64'h5555AAAA0000FFFF);
    tick();
    check("d_ok_single", 64'(bi.dresp_data_ok), 64'd0);
    check("d_data_hold", bi.dresp_data, 64'h5555AAAA0000FFFF);

    // Simultaneous requests, fixed data priority.
    bi.ireq_valid = 1; bi.ireq_addr = 64'h8000_0010;
    bi.dreq_valid = 1; bi.dreq_addr = 64'h8000_2000; bi.dreq_size = 2;
    bi.dreq_strobe = 8'h00; bi.dreq_data = 64'h0;
    tick();
    check("tie_first_addr", bi.creq_addr, 64'h8000_2000);
    check("tie_first_rd", 64'(bi.creq_is_write), 64'd0);
    bi.cresp_ready = 1; bi.cresp_last = 1; bi.cresp_data = 64'h1;
    tick();
    bi.cresp_ready = 0; bi.cresp_last = 0;
    check("tie_dok", 64'(bi.dresp_data_ok), 64'd1);
    check("tie_no_iok", 64'(bi.iresp_data_ok), 64'd0);
    bi.dreq_valid = 0;
    tick();
    check("tie_idle_no_req", 64'(bi.creq_valid), 64'd0);
    tick();
    check("tie_second_addr", bi.creq_addr, 64'h8000_0010);
    bi.cresp_ready = 1; bi.cresp_last = 1; bi.cresp_data = 64'h2222333344445555;
    tick();
    bi.cresp_ready = 0; bi.cresp_last = 0;
    bi.ireq_valid = 0;
    check("tie_iok", 64'(bi.iresp_data_ok), 64'd1);
    check("tie_no_dok", 64'(bi.dresp_data_ok), 64'd0);
    check("tie_idata", 64'(bi.iresp_data), 64'h44445555);
    tick();

    // Round-robin instance: an instruction warm-up makes data next in line.
    br.cresp_ready = 1; br.cresp_last = 1;
    br.ireq_valid = 1; br.ireq_addr = 64'h100;
    br.dreq_addr = 64'h200; br.dreq_size = 3;
    tick();
    tick();
    check("rr_warm_iok", 64'(br.iresp_data_ok), 64'd1);
    br.dreq_valid = 1;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_valid", 64'(br.creq_valid), 64'd1);
      check("rr_grant", br.creq_addr, (k % 2 == 0) ? 64'h200 : 64'h100);
      tick();
      check("rr_dok", 64'(br.dresp_data_ok), (k % 2 == 0) ? 64'd1 : 64'd0);
      check("rr_iok", 64'(br.iresp_data_ok), (k % 2 == 0) ? 64'd0 : 64'd1);
      tick();
    end
    br.ireq_valid = 0; br.dreq_valid = 0;
    br.cresp_ready = 0; br.cresp_last = 0;

    // Asynchronous reset in the middle of BUSY_D.
    bi.dreq_valid = 1; bi.dreq_addr = 64'h3000; bi.dreq_size = 2;
    bi.dreq_strobe = 8'h0F; bi.dreq_data = 64'h77;
    tick();
    check("ar_busy", 64'(bi.creq_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_creq_valid", 64'(bi.creq_valid), 64'd0);
    check("ar_creq_addr", bi.creq_addr, 64'd0);
    check("ar_creq_wr", 64'(bi.creq_is_write), 64'd0);
    check("ar_dresp_data", bi.dresp_data, 64'd0);
    check("ar_iresp_data", 64'(bi.iresp_data), 64'd0);
    check("ar_dok", 64'(bi.dresp_data_ok), 64'd0);
    bi.dreq_valid = 0;
    tick();
    reset = 1'b0;
    tick();
    check("ar_post_valid", 64'(bi.creq_valid), 64'd0);
    check("ar_post_dok", 64'(bi.dresp_data_ok), 64'd0);
    tick();
    check("ar_post_dok2", 64'(bi.dresp_data_ok), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
